alu_sequencer: RTL and testbench

Multi-cycle control FSM that sequences the 8-bit arithmetic unit and the COPNZ flag register of the SIMP datapath. It accepts one instruction at a time over a valid/ready handshake and steps operand loads, ALU operation and result writeback. It drives the flag-register load strobe (the flag unit's `i7`) and the `leq` qualifier, and resolves conditional jumps against the latched flags. It sits between instruction fetch/decode and the ALU/flag datapath.

---
 rtl/alu_sequencer_if.sv | 38 +++
 rtl/alu_sequencer.sv | 177 +++++++++++++++++
 tb/tb_alu_sequencer.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/alu_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : alu_sequencer_if
//  Brief    : Instruction handshake and ALU/flag/PC control bundle for the
//             SIMP ALU sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
interface alu_sequencer_if;
  logic       instr_valid;
  logic       instr_ready;
  logic [3:0] opcode;
  logic [2:0] cond;
  logic [4:0] flags;
  logic       ld_a;
  logic       ld_b;
  logic [2:0] alu_op;
  logic       leq;
  logic       flag_ld;
  logic       acc_we;
  logic       pc_inc;
  logic       pc_load;
  logic       done;
  logic       err;
  logic [7:0] retired;

  modport master (
    output instr_valid, opcode, cond, flags,
    input  instr_ready, ld_a, ld_b, alu_op, leq, flag_ld, acc_we,
           pc_inc, pc_load, done, err, retired
  );

  modport slave (
    input  instr_valid, opcode, cond, flags,
    output instr_ready, ld_a, ld_b, alu_op, leq, flag_ld, acc_we,
           pc_inc, pc_load, done, err, retired
  );
endinterface
`default_nettype wire

// File: rtl/alu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : alu_sequencer
//  Brief    : Multi-cycle control FSM sequencing operand loads, ALU op,
//             flag/accumulator writeback and conditional jumps.
//  Revision : 1.0 - initial release
// ============================================================================
module alu_sequencer (
  input wire           ck,
  input wire           rst,
  alu_sequencer_if.slave bus
);

  localparam logic [3:0] c_OP_NOP = 4'h0;
  localparam logic [3:0] c_OP_CMP = 4'h8;
  localparam logic [3:0] c_OP_JCC = 4'h9;
  localparam logic [2:0] c_ALU_SUB = 3'd2;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_A = 3'd1,
    S_LOAD_B = 3'd2,
    S_EXEC   = 3'd3,
    S_WB     = 3'd4,
    S_BRANCH = 3'd5
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [3:0] r_opcode;
  logic [2:0] r_cond;
  logic       r_err;
  logic [7:0] r_retired;

  logic       w_ready;
  logic       w_accept;
  logic       w_in_alu;
  logic       w_in_illegal;
  logic       w_is_alu;
  logic       w_is_cmp;
  logic [2:0] w_op;
  logic       w_taken;
  logic       w_ld_a;
  logic       w_ld_b;
  logic [2:0] w_alu_op;
  logic       w_leq;
  logic       w_flag_ld;
  logic       w_acc_we;
  logic       w_pc_inc;
  logic       w_pc_load;
  logic       w_done;

  // Ready is gated by rst so a handshake coincident with reset is never taken.
  assign w_ready      = (r_state == S_IDLE) && !r_err && !rst;
  assign w_accept     = bus.instr_valid && w_ready;
  assign w_in_alu     = (bus.opcode[3] == 1'b0) && (bus.opcode != c_OP_NOP);
  assign w_in_illegal = (bus.opcode > c_OP_JCC);

  assign w_is_alu = (r_opcode[3] == 1'b0) && (r_opcode != c_OP_NOP);
  assign w_is_cmp = (r_opcode == c_OP_CMP);
  assign w_op     = w_is_cmp ? c_ALU_SUB : r_opcode[2:0];

  // flags = {C,O,P,N,Z}
  always_comb begin
    w_taken = 1'b0;
    case (r_cond)
      3'd0:    w_taken = 1'b1;
      3'd1:    w_taken = bus.flags[4];
      3'd2:    w_taken = bus.flags[3];
      3'd3:    w_taken = bus.flags[2];
      3'd4:    w_taken = bus.flags[1];
      3'd5:    w_taken = bus.flags[0];
      3'd6:    w_taken = !bus.flags[0];
      default: w_taken = !bus.flags[1];
    endcase
  end

  always_ff @(posedge ck) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ld_a      = 1'b0;
    w_ld_b      = 1'b0;
    w_alu_op    = 3'd0;
    w_leq       = 1'b0;
    w_flag_ld   = 1'b0;
    w_acc_we    = 1'b0;
    w_pc_inc    = 1'b0;
    w_pc_load   = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_in_illegal) begin
            w_state_nxt = S_IDLE;
          end else if (bus.opcode == c_OP_JCC) begin
            w_state_nxt = S_BRANCH;
          end else if (w_in_alu || (bus.opcode == c_OP_CMP)) begin
            w_state_nxt = S_LOAD_A;
          end else begin
            w_state_nxt = S_WB;
          end
        end
      end
      S_LOAD_A: begin
        w_ld_a      = 1'b1;
        w_state_nxt = S_LOAD_B;
      end
      S_LOAD_B: begin
        w_ld_b      = 1'b1;
        w_state_nxt = S_EXEC;
      end
      S_EXEC: begin
        w_alu_op    = w_op;
        w_leq       = w_is_cmp;
        w_state_nxt = S_WB;
      end
      S_WB: begin
        w_alu_op    = w_op;
        w_leq       = w_is_cmp;
        w_flag_ld   = w_is_alu || w_is_cmp;
        w_acc_we    = w_is_alu;
        w_pc_inc    = 1'b1;
        w_done      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      S_BRANCH: begin
        w_pc_load   = w_taken;
        w_pc_inc    = !w_taken;
        w_done      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge ck) begin
    if (rst) begin
      r_opcode  <= 4'd0;
      r_cond    <= 3'd0;
      r_err     <= 1'b0;
      r_retired <= 8'd0;
    end else begin
      r_err <= w_accept && w_in_illegal;
      if (w_accept) begin
        r_opcode <= bus.opcode;
        r_cond   <= bus.cond;
      end
      if (w_done) begin
        r_retired <= r_retired + 8'd1;
      end
    end
  end

  assign bus.instr_ready = w_ready;
  assign bus.ld_a        = w_ld_a;
  assign bus.ld_b        = w_ld_b;
  assign bus.alu_op      = w_alu_op;
  assign bus.leq         = w_leq;
  assign bus.flag_ld     = w_flag_ld;
  assign bus.acc_we      = w_acc_we;
  assign bus.pc_inc      = w_pc_inc;
  assign bus.pc_load     = w_pc_load;
  assign bus.done        = w_done;
  assign bus.err         = r_err;
  assign bus.retired     = r_retired;

endmodule
`default_nettype wire

// File: tb/tb_alu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_sequencer
//  Brief    : Directed self-checking bench for alu_sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu_sequencer;

  logic ck = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;
  int   exp_ret  = 0;

  always #5 ck = ~ck;

  alu_sequencer_if bus ();

  alu_sequencer u_dut (
    .ck  (ck),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic adv();
    @(posedge ck);
    #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [2:0] cc);
    bus.instr_valid = 1'b1;
    bus.opcode      = op;
    bus.cond        = cc;
    adv();
    bus.instr_valid = 1'b0;
    bus.opcode      = 4'hF;
    bus.cond        = 3'd0;
  endtask

  typedef struct {
    logic [2:0] cc;
    logic [4:0] fl;
    logic       taken;
  } jcc_vec_t;

  jcc_vec_t jv [8];

  initial begin
    int bad_pat;
    int n_done;

    jv[0] = '{3'd0, 5'b00000, 1'b1};
    jv[1] = '{3'd1, 5'b10000, 1'b1};
    jv[2] = '{3'd2, 5'b01000, 1'b1};
    jv[3] = '{3'd3, 5'b00000, 1'b0};
    jv[4] = '{3'd4, 5'b00010, 1'b1};
    jv[5] = '{3'd5, 5'b00000, 1'b0};
    jv[6] = '{3'd6, 5'b00001, 1'b0};
    jv[7] = '{3'd7, 5'b00000, 1'b1};

    rst             = 1'b1;
    bus.instr_valid = 1'b1;
    bus.opcode      = 4'h1;
    bus.cond        = 3'd0;
    bus.flags       = 5'd0;
    adv();
    adv();
    chk("rst_ready", 32'(bus.instr_ready), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_ld_a", 32'(bus.ld_a), 32'd0);
    chk("rst_retired", 32'(bus.retired), 32'd0);
    bus.instr_valid = 1'b0;
    rst = 1'b0;
    adv();
    chk("ready_after_rst", 32'(bus.instr_ready), 32'd1);

    // ADD
    issue(4'h1, 3'd0);
    chk("add_ld_a", 32'(bus.ld_a), 32'd1);
    chk("add_ld_a_ready", 32'(bus.instr_ready), 32'd0);
    adv();
    chk("add_ld_b", 32'(bus.ld_b), 32'd1);
    chk("add_ld_b_lda", 32'(bus.ld_a), 32'd0);
    adv();
    chk("add_exec_op", 32'(bus.alu_op), 32'd1);
    chk("add_exec_flag_ld", 32'(bus.flag_ld), 32'd0);
    chk("add_exec_done", 32'(bus.done), 32'd0);
    adv();
    chk("add_wb_op", 32'(bus.alu_op), 32'd1);
    chk("add_wb_flag_ld", 32'(bus.flag_ld), 32'd1);
    chk("add_wb_acc_we", 32'(bus.acc_we), 32'd1);
    chk("add_wb_pc_inc", 32'(bus.pc_inc), 32'd1);
    chk("add_wb_done", 32'(bus.done), 32'd1);
    chk("add_wb_leq", 32'(bus.leq), 32'd0);
    adv();
    exp_ret = 1;
    chk("add_retired", 32'(bus.retired), 32'(exp_ret));
    chk("add_ready_back", 32'(bus.instr_ready), 32'd1);

    // CMP then JCC Z
    issue(4'h8, 3'd0);
    adv();
    adv();
    chk("cmp_exec_leq", 32'(bus.leq), 32'd1);
    adv();
    chk("cmp_wb_leq", 32'(bus.leq), 32'd1);
    chk("cmp_wb_flag_ld", 32'(bus.flag_ld), 32'd1);
    chk("cmp_wb_acc_we", 32'(bus.acc_we), 32'd0);
    chk("cmp_wb_done", 32'(bus.done), 32'd1);
    adv();
    exp_ret++;
    chk("cmp_leq_idle", 32'(bus.leq), 32'd0);
    bus.flags = 5'b00001;
    issue(4'h9, 3'd5);
    chk("jz_pc_load", 32'(bus.pc_load), 32'd1);
    chk("jz_pc_inc", 32'(bus.pc_inc), 32'd0);
    chk("jz_done", 32'(bus.done), 32'd1);
    chk("jz_flag_ld", 32'(bus.flag_ld), 32'd0);
    adv();
    exp_ret++;

    // Condition table
    for (int i = 0; i < 8; i++) begin
      bus.flags = jv[i].fl;
      issue(4'h9, jv[i].cc);
      chk($sformatf("jcc%0d_pc_load", i), 32'(bus.pc_load), 32'(jv[i].taken));
      chk($sformatf("jcc%0d_pc_inc", i), 32'(bus.pc_inc), 32'(!jv[i].taken));
      chk($sformatf("jcc%0d_done", i), 32'(bus.done), 32'd1);
      adv();
      exp_ret++;
    end
    chk("jcc_retired", 32'(bus.retired), 32'(exp_ret));

    // Illegal opcode
    issue(4'hC, 3'd0);
    chk("ill_err", 32'(bus.err), 32'd1);
    chk("ill_done", 32'(bus.done), 32'd0);
    chk("ill_pc_inc", 32'(bus.pc_inc), 32'd0);
    chk("ill_flag_ld", 32'(bus.flag_ld), 32'd0);
    chk("ill_ready", 32'(bus.instr_ready), 32'd0);
    adv();
    chk("ill_err_clear", 32'(bus.err), 32'd0);
    chk("ill_ready_back", 32'(bus.instr_ready), 32'd1);
    chk("ill_retired", 32'(bus.retired), 32'(exp_ret));

    // Reset during LOAD_B of SUB
    issue(4'h2, 3'd0);
    adv();
    chk("sub_ld_b", 32'(bus.ld_b), 32'd1);
    rst = 1'b1;
    adv();
    chk("abort_ld_b", 32'(bus.ld_b), 32'd0);
    chk("abort_alu_op", 32'(bus.alu_op), 32'd0);
    chk("abort_flag_ld", 32'(bus.flag_ld), 32'd0);
    chk("abort_acc_we", 32'(bus.acc_we), 32'd0);
    chk("abort_done", 32'(bus.done), 32'd0);
    chk("abort_ready", 32'(bus.instr_ready), 32'd0);
    chk("abort_retired", 32'(bus.retired), 32'd0);
    rst = 1'b0;
    adv();
    chk("abort_ready_back", 32'(bus.instr_ready), 32'd1);
    issue(4'h0, 3'd0);
    chk("nop_done", 32'(bus.done), 32'd1);
    chk("nop_pc_inc", 32'(bus.pc_inc), 32'd1);
    chk("nop_flag_ld", 32'(bus.flag_ld), 32'd0);
    chk("nop_acc_we", 32'(bus.acc_we), 32'd0);
    adv();
    chk("nop_retired", 32'(bus.retired), 32'd1);

    // 256 back-to-back NOPs from a fresh reset
    rst = 1'b1;
    adv();
    rst = 1'b0;
    adv();
    bus.instr_valid = 1'b1;
    bus.opcode      = 4'h0;
    bad_pat = 0;
    n_done  = 0;
    for (int i = 0; i < 512; i++) begin
      adv();
      if (bus.done !== ((i % 2) == 0)) bad_pat++;
      if (bus.done === 1'b1) n_done++;
      if (i == 509) chk("nop255_retired", 32'(bus.retired), 32'd255);
    end
    chk("nop_pattern", 32'(bad_pat), 32'd0);
    chk("nop_count", 32'(n_done), 32'd256);
    chk("nop_wrap", 32'(bus.retired), 32'd0);
    bus.instr_valid = 1'b0;
    adv();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
